// File: rtl/dds_phase_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : dds_phase_accumulator_if
// Description : Control, FTW handshake and ROM-address bundle for the DDS
//               phase accumulator.
//   en          accumulate enable
//   phase_clr   synchronous accumulator clear (priority over en)
//   ftw_in      frequency tuning word, qualified by ftw_valid
//   ftw_valid   ftw_in valid
//   ftw_ready   FTW can be accepted this cycle
//   phase_off   phase offset added to the ROM address
//   raddr       registered ROM read address
//   addr_valid  raddr updated this cycle
//   rom_valid   ROM data output valid (addr_valid delayed one cycle)
//   wrap        one-cycle accumulator carry-out pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface dds_phase_accumulator_if #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 12
);
  logic              en;
  logic              phase_clr;
  logic [ACC_W-1:0]  ftw_in;
  logic              ftw_valid;
  logic              ftw_ready;
  logic [ADDR_W-1:0] phase_off;
  logic [ADDR_W-1:0] raddr;
  logic              addr_valid;
  logic              rom_valid;
  logic              wrap;

  modport master (
    output en, phase_clr, ftw_in, ftw_valid, phase_off,
    input  ftw_ready, raddr, addr_valid, rom_valid, wrap
  );

  modport slave (
    input  en, phase_clr, ftw_in, ftw_valid, phase_off,
    output ftw_ready, raddr, addr_valid, rom_valid, wrap
  );
endinterface
`default_nettype wire

// File: rtl/dds_phase_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : dds_phase_accumulator
// Description : DDS phase accumulator front end. Integrates the active FTW on
//               every enabled cycle, adds a phase offset to the top ADDR_W
//               bits and registers the result as the wavetable ROM address.
//               FTW updates arrive over a valid/ready handshake and, with
//               SYNC_UPDATE=1 while running, are held until the next
//               accumulator wrap so the phase stays continuous.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - dds_phase_accumulator_if.slave (control, handshake,
//                       ROM address and strobes)
// Revision    : 1.0 - initial release
// ============================================================================
module dds_phase_accumulator #(
  parameter int ACC_W       = 32,
  parameter int ADDR_W      = 12,
  parameter bit SYNC_UPDATE = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  dds_phase_accumulator_if.slave       bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [ACC_W-1:0]  ftw_active, ftw_active_nxt;
  logic [ACC_W-1:0]  ftw_pending, ftw_pending_nxt;
  logic              pend_flag, pend_flag_nxt;
  logic [ADDR_W-1:0] raddr, raddr_nxt;
  logic              addr_valid, addr_valid_nxt;
  logic              rom_valid;
  logic              wrap, wrap_nxt;

  logic [ACC_W:0]    sum;
  logic              carry;
  logic              xfer;
  logic              run;

  // Ready depends only on registered state, never on ftw_valid.
  assign bus.ftw_ready  = ~pend_flag;
  assign bus.raddr      = raddr;
  assign bus.addr_valid = addr_valid;
  assign bus.rom_valid  = rom_valid;
  assign bus.wrap       = wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      ftw_active  <= '0;
      ftw_pending <= '0;
      pend_flag   <= 1'b0;
      raddr       <= '0;
      addr_valid  <= 1'b0;
      rom_valid   <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      ftw_active  <= ftw_active_nxt;
      ftw_pending <= ftw_pending_nxt;
      pend_flag   <= pend_flag_nxt;
      raddr       <= raddr_nxt;
      addr_valid  <= addr_valid_nxt;
      // One-cycle delay matches the ROM read latency.
      rom_valid   <= addr_valid;
      wrap        <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt       = bus.en ? RUN : IDLE;
    // The mode in force for this cycle's update is the one being entered.
    run             = (state_nxt == RUN);
    sum             = {1'b0, acc} + {1'b0, ftw_active};
    carry           = 1'b0;
    acc_nxt         = acc;
    raddr_nxt       = raddr;
    addr_valid_nxt  = 1'b0;
    wrap_nxt        = 1'b0;
    ftw_active_nxt  = ftw_active;
    ftw_pending_nxt = ftw_pending;
    pend_flag_nxt   = pend_flag;
    xfer            = bus.ftw_valid & ~pend_flag;

    if (bus.phase_clr) begin
      acc_nxt        = '0;
      raddr_nxt      = bus.phase_off;
      addr_valid_nxt = bus.en;
    end else if (run) begin
      acc_nxt        = sum[ACC_W-1:0];
      carry          = sum[ACC_W];
      // Address is formed from the new accumulator value so raddr has no
      // extra lag relative to acc.
      raddr_nxt      = sum[ACC_W-1 -: ADDR_W] + bus.phase_off;
      addr_valid_nxt = 1'b1;
      wrap_nxt       = carry;
    end

    // A pending word is applied at a wrap (the wrap sum above still used the
    // old word). If the accumulator cannot wrap (zero step, or stopped) it is
    // applied straight away so the handshake never deadlocks. A transfer in
    // the same cycle cannot collide: ready is low while a word is pending.
    if (pend_flag && (carry || (ftw_active == '0) || (state == IDLE))) begin
      ftw_active_nxt = ftw_pending;
      pend_flag_nxt  = 1'b0;
    end else if (xfer) begin
      if (!SYNC_UPDATE || !run) begin
        ftw_active_nxt = bus.ftw_in;
      end else begin
        ftw_pending_nxt = bus.ftw_in;
        pend_flag_nxt   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dds_phase_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_phase_accumulator
// Description : Self-checking bench for dds_phase_accumulator. Drives one
//               SYNC_UPDATE=0 and one SYNC_UPDATE=1 instance with the same
//               stimulus and compares both against a behavioural model,
//               with directed sweeps followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_phase_accumulator;

  localparam int ACC_W  = 32;
  localparam int ADDR_W = 12;

  logic clk;
  logic rst_n;

  logic              drv_en;
  logic              drv_phase_clr;
  logic [ACC_W-1:0]  drv_ftw_in;
  logic              drv_ftw_valid;
  logic [ADDR_W-1:0] drv_phase_off;

  int checks = 0;
  int errors = 0;

  dds_phase_accumulator_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus0 ();
  dds_phase_accumulator_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus1 ();

  assign bus0.en        = drv_en;
  assign bus0.phase_clr = drv_phase_clr;
  assign bus0.ftw_in    = drv_ftw_in;
  assign bus0.ftw_valid = drv_ftw_valid;
  assign bus0.phase_off = drv_phase_off;
  assign bus1.en        = drv_en;
  assign bus1.phase_clr = drv_phase_clr;
  assign bus1.ftw_in    = drv_ftw_in;
  assign bus1.ftw_valid = drv_ftw_valid;
  assign bus1.phase_off = drv_phase_off;

  dds_phase_accumulator #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .SYNC_UPDATE(1'b0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  dds_phase_accumulator #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .SYNC_UPDATE(1'b1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: index 0 = direct update, index 1 = wrap-synchronous.
  logic [31:0] m_acc   [2];
  logic [31:0] m_fa    [2];
  logic [31:0] m_pw    [2];
  bit          m_pend  [2];
  bit          m_run   [2];
  logic [11:0] m_raddr [2];
  bit          m_av    [2];
  bit          m_rv    [2];
  bit          m_wrap  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = '0; m_fa[k] = '0; m_pw[k] = '0; m_pend[k] = 1'b0; m_run[k] = 1'b0;
      m_raddr[k] = '0; m_av[k] = 1'b0; m_rv[k] = 1'b0; m_wrap[k] = 1'b0;
    end
  endtask

  // Advance one clock of the model for instance k using the driven inputs.
  task automatic model_step(input int k, input bit sync);
    longint unsigned total;
    bit              carry;
    bit              accepted;
    logic [31:0]     old_fa;
    carry    = 1'b0;
    old_fa   = m_fa[k];
    accepted = drv_ftw_valid && !m_pend[k];
    m_rv[k]  = m_av[k];
    if (drv_phase_clr) begin
      m_acc[k] = 0; m_raddr[k] = drv_phase_off; m_av[k] = drv_en; m_wrap[k] = 1'b0;
    end else if (drv_en) begin
      total      = longint'(m_acc[k]) + longint'(old_fa);
      carry      = (total >= 64'h1_0000_0000);
      m_acc[k]   = 32'(total % 64'h1_0000_0000);
      m_raddr[k] = 12'((m_acc[k] / 32'h0010_0000 + 32'(drv_phase_off)) % 4096);
      m_av[k]    = 1'b1;
      m_wrap[k]  = carry;
    end else begin
      m_av[k] = 1'b0; m_wrap[k] = 1'b0;
    end
    if (m_pend[k] && (carry || old_fa == 0 || !m_run[k])) begin
      m_fa[k] = m_pw[k]; m_pend[k] = 1'b0;
    end else if (accepted) begin
      if (!sync || !drv_en) m_fa[k] = drv_ftw_in;
      else begin m_pw[k] = drv_ftw_in; m_pend[k] = 1'b1; end
    end
    m_run[k] = drv_en;
  endtask

  task automatic compare_all();
    check("u0_raddr",     32'(bus0.raddr),      32'(m_raddr[0]));
    check("u0_addr_valid",32'(bus0.addr_valid), 32'(m_av[0]));
    check("u0_rom_valid", 32'(bus0.rom_valid),  32'(m_rv[0]));
    check("u0_wrap",      32'(bus0.wrap),       32'(m_wrap[0]));
    check("u0_ftw_ready", 32'(bus0.ftw_ready),  32'(!m_pend[0]));
    check("u1_raddr",     32'(bus1.raddr),      32'(m_raddr[1]));
    check("u1_addr_valid",32'(bus1.addr_valid), 32'(m_av[1]));
    check("u1_rom_valid", 32'(bus1.rom_valid),  32'(m_rv[1]));
    check("u1_wrap",      32'(bus1.wrap),       32'(m_wrap[1]));
    check("u1_ftw_ready", 32'(bus1.ftw_ready),  32'(!m_pend[1]));
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are sampled
  // at the same offset after the next one.
  task automatic cycle();
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_raddr"}, {20'd0, bus0.raddr, bus1.raddr} , 32'd0);
    check({tag, "_strobes"}, {26'd0, bus0.addr_valid, bus0.rom_valid, bus0.wrap,
                              bus1.addr_valid, bus1.rom_valid, bus1.wrap}, 32'd0);
    check({tag, "_ready"}, {30'd0, bus0.ftw_ready, bus1.ftw_ready}, 32'd3);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("async_rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    drv_en = 1'b0; drv_phase_clr = 1'b0; drv_ftw_in = '0; drv_ftw_valid = 1'b0; drv_phase_off = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Basic sweep: FTW loaded while idle, step of one address per cycle.
    drv_ftw_in = 32'h0010_0000; drv_ftw_valid = 1'b1;
    cycle();
    drv_ftw_valid = 1'b0; drv_en = 1'b1;
    cycle();
    check("sweep_first_raddr", 32'(bus1.raddr), 32'h1);
    check("sweep_first_av",    32'(bus1.addr_valid), 32'h1);
    check("sweep_first_rv",    32'(bus1.rom_valid), 32'h0);
    cycle();
    check("sweep_second_rv",   32'(bus1.rom_valid), 32'h1);
    repeat (4094) cycle();
    check("sweep_wrap_raddr",  32'(bus1.raddr), 32'h0);
    check("sweep_wrap_pulse",  32'(bus1.wrap), 32'h1);
    cycle();
    check("sweep_wrap_single", 32'(bus1.wrap), 32'h0);

    // Offset sweep: offset wrap of raddr must not raise wrap.
    drv_phase_clr = 1'b1; drv_phase_off = 12'h800;
    cycle();
    drv_phase_clr = 1'b0;
    cycle();
    check("offset_first_raddr", 32'(bus1.raddr), 32'h801);
    repeat (4095) cycle();
    check("offset_wrap_raddr", 32'(bus1.raddr), 32'h800);
    check("offset_wrap_pulse", 32'(bus1.wrap), 32'h1);

    // Wrap-synchronous FTW update.
    drv_phase_off = 12'h000;
    repeat (256) cycle();
    check("sync_pre_raddr", 32'(bus1.raddr), 32'h100);
    drv_ftw_in = 32'h0020_0000; drv_ftw_valid = 1'b1;
    cycle();
    drv_ftw_valid = 1'b0;
    check("sync_ready_low", 32'(bus1.ftw_ready), 32'h0);
    n = 0;
    while (bus1.wrap !== 1'b1 && n < 5000) begin
      cycle();
      n++;
    end
    check("sync_wrap_seen", 32'(bus1.wrap), 32'h1);
    check("sync_wrap_raddr", 32'(bus1.raddr), 32'h0);
    check("sync_ready_back", 32'(bus1.ftw_ready), 32'h1);
    cycle();
    check("sync_step2_raddr", 32'(bus1.raddr), 32'h2);

    // Zero active FTW while running: pending word applies next cycle.
    drv_en = 1'b0; drv_ftw_in = 32'h0; drv_ftw_valid = 1'b1;
    cycle();
    drv_ftw_valid = 1'b0; drv_en = 1'b1;
    cycle();
    drv_ftw_in = 32'h0010_0000; drv_ftw_valid = 1'b1;
    cycle();
    drv_ftw_valid = 1'b0;
    check("zero_ftw_pending", 32'(bus1.ftw_ready), 32'h0);
    cycle();
    check("zero_ftw_applied", 32'(bus1.ftw_ready), 32'h1);
    repeat (3) cycle();

    // Phase clear mid-sweep with a word pending.
    drv_ftw_in = 32'h0020_0000; drv_ftw_valid = 1'b1;
    cycle();
    drv_ftw_valid = 1'b0; drv_phase_clr = 1'b1; drv_phase_off = 12'h010;
    cycle();
    check("clr_raddr", 32'(bus1.raddr), 32'h010);
    check("clr_wrap", 32'(bus1.wrap), 32'h0);
    check("clr_pending_kept", 32'(bus1.ftw_ready), 32'h0);
    drv_phase_clr = 1'b0;
    cycle();
    check("clr_next_raddr", 32'(bus1.raddr), 32'h011);

    // Asynchronous reset with a word still pending.
    async_reset();
    drv_en = 1'b0;
    repeat (2) cycle();
    drv_en = 1'b1;
    repeat (4) cycle();
    check("post_rst_raddr", 32'(bus1.raddr), 32'h010);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drv_en        = ($urandom_range(0, 9) != 0);
      drv_phase_clr = ($urandom_range(0, 31) == 0);
      drv_ftw_valid = ($urandom_range(0, 3) == 0);
      drv_phase_off = 12'($urandom);
      case ($urandom_range(0, 3))
        0: drv_ftw_in = 32'h0;
        1: drv_ftw_in = 32'($urandom);
        2: drv_ftw_in = 32'($urandom_range(1, 255)) << 20;
        default: drv_ftw_in = 32'($urandom_range(1, 4095)) << 16;
      endcase
      if ($urandom_range(0, 499) == 0) async_reset();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dds_phase_accumulator.md
Name: dds_phase_accumulator

Overview:
Phase-accumulator front end of the DDS core. It integrates a frequency tuning word (FTW) every enabled clock and adds a phase offset. It drives the registered 12-bit read address into the 4096-entry, 24-bit wavetable ROM (1-cycle read latency). It also emits a valid strobe aligned to the ROM data output, a per-cycle wrap pulse, and accepts FTW updates over a valid/ready handshake with optional phase-continuous (wrap-synchronous) application.

Parameters:
ACC_W, 32, accumulator width in bits
ADDR_W, 12, ROM address width; address = acc[ACC_W-1 -: ADDR_W] + phase_off
SYNC_UPDATE, 1, 1 = new FTW applied only at accumulator wrap while running; 0 = applied next cycle

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  accumulate enable
phase_clr  in  1  synchronous accumulator clear, priority over en
ftw_in  in  ACC_W  frequency tuning word
ftw_valid  in  1  ftw_in valid
ftw_ready  out  1  FTW can be accepted this cycle
phase_off  in  ADDR_W  phase offset added to address, sampled every cycle
raddr  out  ADDR_W  registered ROM read address
addr_valid  out  1  raddr updated this cycle
rom_valid  out  1  ROM dout valid (addr_valid delayed 1 cycle)
wrap  out  1  1-cycle pulse: accumulator carry-out this cycle

Behaviour:
- Reset (rst_n=0, async): acc=0, ftw_active=0, ftw_pending=0, pend_flag=0, raddr=0, addr_valid=0, rom_valid=0, wrap=0, state=IDLE. ftw_ready reads 1 (combinational = !pend_flag).
- States: IDLE (en=0), RUN (en=1). Transitions: IDLE->RUN when en=1; RUN->IDLE when en=0. Evaluated every cycle.
- Handshake: transfer when ftw_valid && ftw_ready. ftw_ready = !pend_flag. No combinational path from ftw_valid to ftw_ready.
  - SYNC_UPDATE=0, or state IDLE: ftw_active <= ftw_in. The new word is used from the next accumulation.
  - SYNC_UPDATE=1 and state RUN: ftw_pending <= ftw_in and pend_flag <= 1.
  - Pending apply: on a cycle with carry-out=1, ftw_active <= ftw_pending and pend_flag <= 0. The wrap-cycle sum still uses the old word.
  - Transfer in the same cycle as a wrap: the word is stored pending and applies at the next wrap, not this one.
  - If ftw_active==0 or the state is IDLE while pend_flag=1: apply the pending word on the next cycle. This avoids deadlock when the accumulator never wraps.
- Accumulate (RUN, phase_clr=0):
  - {carry, acc} <= acc + ftw_active, unsigned, mod 2^ACC_W.
  - raddr <= (sum[ACC_W-1 -: ADDR_W] + phase_off) mod 2^ADDR_W, where sum is the new acc value, so raddr tracks acc with no extra lag.
  - addr_valid <= 1; wrap <= carry.
- IDLE: acc and raddr hold; addr_valid=0; wrap=0.
- phase_clr=1, any state: acc <= 0; raddr <= phase_off; addr_valid <= en; wrap <= 0. ftw_active and pend_flag are unaffected.
- rom_valid <= addr_valid every cycle. This gives a 1-cycle delay matching the ROM, so rom_valid is high exactly when ROM dout corresponds to a raddr flagged valid.
- Latency: FTW accepted at cycle t (non-sync) affects acc at t+2 and raddr at t+2. en rise at cycle t gives first addr_valid at t+1 and first rom_valid at t+2.
- Reset mid-operation clears all state, including any pending FTW. After reset is released, the first transfer goes direct (IDLE).

Test Plan:
- Reset, load FTW=0x0010_0000 while IDLE, then en=1 -> raddr = 1,2,3,…; addr_valid high from the first enabled cycle; rom_valid one cycle later; after 4096 cycles raddr=0 with wrap=1 for exactly one cycle.
- FTW=0x0010_0000, phase_off=0x800 -> first raddr=0x801; raddr wraps 0xFFF->0x000 with wrap=0 (offset wrap is not an accumulator wrap); wrap=1 coincides with raddr=0x800.
- SYNC_UPDATE=1, running with FTW=0x0010_0000, load 0x0020_0000 at raddr=0x100 -> ftw_ready=0 until the wrap cycle; step stays 1 until raddr=0x000/wrap, then step=2 (0x002, 0x004…); ftw_ready returns to 1.
- SYNC_UPDATE=1, ftw_active=0 while running, load 0x0010_0000 -> applied the next cycle; raddr starts incrementing; no hang.
- Assert phase_clr with en=1, phase_off=0x010, mid-sweep -> next raddr=0x010, following raddr=0x011; wrap=0; pending word retained.
- Drop rst_n asynchronously mid-run with pend_flag=1 -> all outputs 0 immediately; ftw_ready=1; no pending application after release.
